// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read-channel arbiter.
package axi_rd_arbiter_pkg;

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned RESP_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b11
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

    // Fixed AR attributes used by the instruction and data memory blocks
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AR/R channel bundles: one per requester, one towards the AXI master port.
interface axi_rd_req_if
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_DATA_WIDTH = 32
) ();
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [LEN_W-1:0]        arlen;
    logic                    arvalid;
    logic                    arready;
    logic [C_DATA_WIDTH-1:0] rdata;
    logic [RESP_W-1:0]       rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (output araddr, arlen, arvalid, rready,
                    input  arready, rdata, rresp, rlast, rvalid);
    modport slave  (input  araddr, arlen, arvalid, rready,
                    output arready, rdata, rresp, rlast, rvalid);
endinterface

interface axi_rd_mst_if
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ID_WIDTH   = 1
) ();
    logic [C_ID_WIDTH-1:0]   arid;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [LEN_W-1:0]        arlen;
    logic                    arvalid;
    logic                    arready;
    logic [C_ID_WIDTH-1:0]   rid;
    logic [C_DATA_WIDTH-1:0] rdata;
    logic [RESP_W-1:0]       rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (output arid, araddr, arlen, arvalid, rready,
                    input  arready, rid, rdata, rresp, rlast, rvalid);
    modport slave  (input  arid, araddr, arlen, arvalid, rready,
                    output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_rd_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not win last time wins.
module rr_arbiter2
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = GNT_NONE;
        case (req)
            2'b01:   gnt_c = GNT_S0;
            2'b10:   gnt_c = GNT_S1;
            2'b11:   gnt_c = last_grant ? GNT_S0 : GNT_S1;
            default: gnt_c = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master (AR/R) between instruction fetch (s0) and data memory (s1),
// one outstanding burst at a time, grant held from AR capture to the RLAST handshake.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ID_WIDTH   = 1
) (
    input  logic         clk,
    input  logic         rst,
    axi_rd_req_if.slave  s0,
    axi_rd_req_if.slave  s1,
    axi_rd_mst_if.master m_axi,
    output logic [1:0]   grant
);

    arb_state_e              state;
    arb_state_e              state_nxt;
    logic                    last_grant;
    logic [1:0]              pick_c;
    logic                    capture;
    logic                    r_done;
    logic [C_ADDR_WIDTH-1:0] win_addr;
    logic [LEN_W-1:0]        win_len;
    logic [C_DATA_WIDTH-1:0] r_data;
    logic                    rid_unused;

    rr_arbiter2 u_rr (
        .req        ({s1.arvalid, s0.arvalid}),
        .last_grant (last_grant),
        .gnt_c      (pick_c)
    );

    assign win_addr   = pick_c[1] ? s1.araddr : s0.araddr;
    assign win_len    = pick_c[1] ? s1.arlen  : s0.arlen;
    assign r_data     = m_axi.rdata;
    // Routing is by grant only; RID is deliberately not compared with ARID
    assign rid_unused = ^m_axi.rid;

    assign capture = (state == ST_IDLE) && (pick_c != GNT_NONE) && !rst;
    assign r_done  = (state == ST_DATA) && m_axi.rvalid && m_axi.rready && m_axi.rlast;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; burst end is RLAST only, no beat counter
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (capture)        state_nxt = ST_ADDR;
            ST_ADDR: if (m_axi.arready)  state_nxt = ST_DATA;
            ST_DATA: if (r_done)         state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: ARREADY pulse on capture, R routed to the owner only while in DATA
    always_comb begin
        s0.arready   = 1'b0;
        s1.arready   = 1'b0;
        s0.rvalid    = 1'b0;
        s0.rdata     = '0;
        s0.rresp     = '0;
        s0.rlast     = 1'b0;
        s1.rvalid    = 1'b0;
        s1.rdata     = '0;
        s1.rresp     = '0;
        s1.rlast     = 1'b0;
        m_axi.rready = 1'b0;
        s0.arready   = capture && pick_c[0];
        s1.arready   = capture && pick_c[1];
        if (state == ST_DATA) begin
            if (grant[0]) begin
                s0.rvalid    = m_axi.rvalid;
                s0.rdata     = r_data;
                s0.rresp     = m_axi.rresp;
                s0.rlast     = m_axi.rlast;
                m_axi.rready = s0.rready;
            end else if (grant[1]) begin
                s1.rvalid    = m_axi.rvalid;
                s1.rdata     = r_data;
                s1.rresp     = m_axi.rresp;
                s1.rlast     = m_axi.rlast;
                m_axi.rready = s1.rready;
            end
        end
    end

    // Registered AR request, grant owner and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi.arvalid <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arlen   <= '0;
            m_axi.arid    <= '0;
            grant         <= GNT_NONE;
            last_grant    <= 1'b1;
        end else if (capture) begin
            m_axi.arvalid <= 1'b1;
            m_axi.araddr  <= win_addr;
            m_axi.arlen   <= win_len;
            m_axi.arid    <= C_ID_WIDTH'(pick_c[1]);
            grant         <= pick_c;
            last_grant    <= pick_c[1];
        end else if ((state == ST_ADDR) && m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arlen   <= '0;
        end else if (r_done) begin
            grant         <= GNT_NONE;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: a transaction-level reference model checks every cycle,
// directed sequences cover the first-request, tie, address-stability and mid-burst reset cases.
module tb_axi_rd_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    axi_rd_req_if s0_if ();
    axi_rd_req_if s1_if ();
    axi_rd_mst_if m_if ();

    axi_rd_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .s0    (s0_if),
        .s1    (s1_if),
        .m_axi (m_if),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: one outstanding transaction, round robin ----------------
    bit          mdl_busy;
    bit          mdl_addr_phase;
    int          mdl_owner;
    int          mdl_last = 1;
    logic [31:0] mdl_addr;
    logic [7:0]  mdl_len;

    logic [1:0]  smp_req;
    logic [1:0]  smp_rready;
    logic [31:0] smp_addr [2];
    logic [7:0]  smp_len  [2];
    logic        smp_arrdy[2];
    logic        smp_rv   [2];
    logic [31:0] smp_rd   [2];
    logic [1:0]  smp_rs   [2];
    logic        smp_rl   [2];
    int          winner;

    always @(negedge clk) begin
        smp_req    = {s1_if.arvalid, s0_if.arvalid};
        smp_rready = {s1_if.rready, s0_if.rready};
        smp_addr[0] = s0_if.araddr;  smp_addr[1] = s1_if.araddr;
        smp_len[0]  = s0_if.arlen;   smp_len[1]  = s1_if.arlen;
        smp_arrdy[0] = s0_if.arready; smp_arrdy[1] = s1_if.arready;
        smp_rv[0] = s0_if.rvalid; smp_rv[1] = s1_if.rvalid;
        smp_rd[0] = s0_if.rdata;  smp_rd[1] = s1_if.rdata;
        smp_rs[0] = s0_if.rresp;  smp_rs[1] = s1_if.rresp;
        smp_rl[0] = s0_if.rlast;  smp_rl[1] = s1_if.rlast;

        winner = -1;
        if (!rst && !mdl_busy) begin
            if (smp_req == 2'b11)  winner = (mdl_last == 0) ? 1 : 0;
            else if (smp_req[0])   winner = 0;
            else if (smp_req[1])   winner = 1;
        end
        check("s0_arready", smp_arrdy[0], winner == 0);
        check("s1_arready", smp_arrdy[1], winner == 1);
        check("grant", grant, !mdl_busy ? 2'b00 : (mdl_owner == 0 ? 2'b01 : 2'b10));
        check("m_arvalid", m_if.arvalid, mdl_busy && mdl_addr_phase);
        if (mdl_busy && mdl_addr_phase) begin
            check("m_araddr", m_if.araddr, mdl_addr);
            check("m_arlen", m_if.arlen, mdl_len);
            check("m_arid", m_if.arid, mdl_owner);
        end else begin
            check("m_araddr_idle", m_if.araddr, 0);
            check("m_arlen_idle", m_if.arlen, 0);
        end
        if (mdl_busy && !mdl_addr_phase) begin
            check("m_rready", m_if.rready, smp_rready[mdl_owner]);
            for (int x = 0; x < 2; x++) begin
                if (x == mdl_owner) begin
                    check("own_rvalid", smp_rv[x], m_if.rvalid);
                    check("own_rdata", smp_rd[x], m_if.rdata);
                    check("own_rresp", smp_rs[x], m_if.rresp);
                    check("own_rlast", smp_rl[x], m_if.rlast);
                end else begin
                    check("other_rvalid", smp_rv[x], 0);
                    check("other_rdata", smp_rd[x], 0);
                end
            end
        end else begin
            check("m_rready_idle", m_if.rready, 0);
            check("s0_rvalid_idle", smp_rv[0], 0);
            check("s1_rvalid_idle", smp_rv[1], 0);
        end

        // advance the model by the edge that follows
        if (rst) begin
            mdl_busy = 0; mdl_addr_phase = 0; mdl_last = 1;
        end else if (winner >= 0) begin
            mdl_busy = 1; mdl_addr_phase = 1; mdl_owner = winner; mdl_last = winner;
            mdl_addr = smp_addr[winner]; mdl_len = smp_len[winner];
        end else if (mdl_busy && mdl_addr_phase && m_if.arready) begin
            mdl_addr_phase = 0;
        end else if (mdl_busy && !mdl_addr_phase && m_if.rvalid &&
                     smp_rready[mdl_owner] && m_if.rlast) begin
            mdl_busy = 0;
        end
    end

    // ---------------- random agents ----------------
    int          p_req[2], p_rready[2], p_arready, p_rvalid;
    bit          pend[2];
    logic [31:0] a_addr[2];
    logic [7:0]  a_len[2];
    bit          a_rready[2];
    int          exp_beats[2], got_beats[2], wait_cyc[2], skips[2];
    int          beats_left;
    logic [7:0]  m_len;
    logic        m_id;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        s0_if.arvalid = pend[0]; s0_if.araddr = a_addr[0]; s0_if.arlen = a_len[0]; s0_if.rready = a_rready[0];
        s1_if.arvalid = pend[1]; s1_if.araddr = a_addr[1]; s1_if.arlen = a_len[1]; s1_if.rready = a_rready[1];
    endtask

    task automatic clear_all();
        for (int x = 0; x < 2; x++) begin
            pend[x] = 0; a_addr[x] = '0; a_len[x] = '0; a_rready[x] = 0;
            exp_beats[x] = 0; got_beats[x] = 0; wait_cyc[x] = 0; skips[x] = 0;
        end
        drive_reqs();
        beats_left = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rlast = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rid = '0;
    endtask

    task automatic agent_step();
        bit ar_hs[2], r_hs[2], r_last[2], m_ar_hs, m_r_hs;
        @(negedge clk);
        ar_hs[0] = s0_if.arvalid && s0_if.arready;
        ar_hs[1] = s1_if.arvalid && s1_if.arready;
        r_hs[0] = s0_if.rvalid && s0_if.rready;  r_last[0] = s0_if.rlast;
        r_hs[1] = s1_if.rvalid && s1_if.rready;  r_last[1] = s1_if.rlast;
        m_ar_hs = m_if.arvalid && m_if.arready;
        m_r_hs  = m_if.rvalid && m_if.rready;
        if (m_ar_hs) begin m_len = m_if.arlen; m_id = m_if.arid; end
        cyc();
        for (int x = 0; x < 2; x++) begin
            if (pend[x]) wait_cyc[x]++;
            if (pend[x] && ar_hs[1-x] && !ar_hs[x]) skips[x]++;
            if (ar_hs[x]) begin
                check("rr_one_txn_wait", skips[x] <= 1, 1);
                check("req_wait_bound", wait_cyc[x] <= 100, 1);
                pend[x] = 0; exp_beats[x] = int'(a_len[x]) + 1; got_beats[x] = 0;
            end
            if (r_hs[x]) begin
                got_beats[x]++;
                if (r_last[x]) check("burst_beats", got_beats[x], exp_beats[x]);
            end
            if (!pend[x] && ($urandom % 100) < p_req[x]) begin
                pend[x] = 1; a_addr[x] = $urandom; a_len[x] = 8'($urandom_range(0, 3));
                wait_cyc[x] = 0; skips[x] = 0;
            end else if (pend[x] && ($urandom % 4) == 0) begin
                a_addr[x] = $urandom;
            end
            a_rready[x] = ($urandom % 100) < p_rready[x];
        end
        drive_reqs();
        if (m_r_hs) begin beats_left--; m_if.rvalid = 0; m_if.rlast = 0; end
        if (m_ar_hs) beats_left = int'(m_len) + 1;
        if (beats_left > 0 && !m_if.rvalid && ($urandom % 100) < p_rvalid) begin
            m_if.rvalid = 1; m_if.rdata = $urandom; m_if.rresp = 2'($urandom_range(0, 3));
            m_if.rlast = (beats_left == 1); m_if.rid = m_id;
        end
        m_if.arready = ($urandom % 100) < p_arready;
    endtask

    task automatic run_phase(input int n, input int r0, input int r1, input int rr0, input int rr1,
                             input int par, input int prv);
        p_req[0] = r0; p_req[1] = r1; p_rready[0] = rr0; p_rready[1] = rr1;
        p_arready = par; p_rvalid = prv;
        for (int i = 0; i < n; i++) agent_step();
    endtask

    initial begin
        rst = 1;
        clear_all();
        cyc(); cyc();
        rst = 0;
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_arvalid", m_if.arvalid, 0);
        check("rst_arid", m_if.arid, 0);

        // single S0 read, master accepts AR after two cycles
        cyc();
        s0_if.arvalid = 1; s0_if.araddr = 32'h100; s0_if.arlen = 0; s0_if.rready = 1;
        @(negedge clk); check("t1_s0_arready", s0_if.arready, 1);
        cyc(); s0_if.arvalid = 0;
        @(negedge clk);
        check("t1_arvalid", m_if.arvalid, 1);
        check("t1_arid", m_if.arid, 0);
        check("t1_araddr", m_if.araddr, 32'h100);
        cyc(); cyc(); m_if.arready = 1;
        cyc(); m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'hDEADBEEF; m_if.rlast = 1; m_if.rresp = 0;
        @(negedge clk);
        check("t1_s0_rdata", s0_if.rdata, 32'hDEADBEEF);
        check("t1_s0_rvalid", s0_if.rvalid, 1);
        check("t1_s1_rvalid", s1_if.rvalid, 0);
        cyc(); m_if.rvalid = 0; m_if.rlast = 0;
        @(negedge clk); check("t1_grant_release", grant, 2'b00);

        // simultaneous requests from reset: S0 first, S1 the cycle after S0's RLAST
        cyc(); rst = 1; cyc(); rst = 0;
        s0_if.arvalid = 1; s0_if.araddr = 32'h200;  s0_if.arlen = 0;
        s1_if.arvalid = 1; s1_if.araddr = 32'h8000; s1_if.arlen = 0; s1_if.rready = 1;
        @(negedge clk);
        check("t2_s0_first", s0_if.arready, 1);
        check("t2_s1_waits", s1_if.arready, 0);
        cyc(); s0_if.arvalid = 0; s1_if.araddr = 32'h9000;
        @(negedge clk); check("t2_addr_stable", m_if.araddr, 32'h200);
        cyc(); s1_if.araddr = 32'h8000; m_if.arready = 1;
        cyc(); m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h11111111; m_if.rlast = 1;
        @(negedge clk); check("t2_s1_busy_ready", s1_if.arready, 0);
        cyc(); m_if.rvalid = 0; m_if.rlast = 0;
        @(negedge clk); check("t2_s1_next", s1_if.arready, 1);
        cyc(); s1_if.arvalid = 0;
        @(negedge clk);
        check("t2_s1_araddr", m_if.araddr, 32'h8000);
        check("t2_s1_arid", m_if.arid, 1);

        // reset while S1's burst is in DATA, then a fresh S1 request
        cyc(); m_if.arready = 1;
        cyc(); m_if.arready = 0; m_if.rvalid = 1; m_if.rlast = 0; m_if.rdata = 32'h22222222; rst = 1;
        cyc(); rst = 0; m_if.rvalid = 0;
        @(negedge clk);
        check("t3_grant", grant, 2'b00);
        check("t3_arvalid", m_if.arvalid, 0);
        check("t3_s0_rvalid", s0_if.rvalid, 0);
        check("t3_s1_rvalid", s1_if.rvalid, 0);
        cyc(); s1_if.arvalid = 1; s1_if.araddr = 32'h8040; s1_if.arlen = 1;
        @(negedge clk); check("t3_s1_arready", s1_if.arready, 1);
        cyc(); s1_if.arvalid = 0; m_if.arready = 1;
        cyc(); m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h33333333;
        cyc(); m_if.rlast = 1; m_if.rdata = 32'h44444444;
        @(negedge clk); check("t3_beat2", s1_if.rdata, 32'h44444444);
        cyc(); m_if.rvalid = 0; m_if.rlast = 0;
        @(negedge clk); check("t3_grant_release", grant, 2'b00);

        // randomized traffic against the model
        cyc(); rst = 1; clear_all(); cyc(); rst = 0;
        run_phase(1500, 30, 30, 80, 80, 50, 75);
        run_phase(1500, 60, 100, 70, 70, 60, 80);
        run_phase(1500, 50, 50, 35, 35, 40, 60);
        run_phase(800, 100, 100, 90, 90, 90, 90);
        for (int x = 0; x < 2; x++) check("no_starvation", wait_cyc[x] <= 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
